// File: rtl/setting_pkg.sv
// Shared types and constants for the panel-button / time-setting front end.
// Holds the setting FSM state type, the default timing constants (1 cycle = 1 ms
// at clk_1khz) and a helper that sizes the debounce and hold counters.
package setting_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_e;

  localparam int unsigned N_DIGITS_DEF    = 6;
  localparam int unsigned DEBOUNCE_MS_DEF = 20;
  localparam int unsigned LONG_MS_DEF     = 1000;
  localparam int unsigned REPEAT_MS_DEF   = 250;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEBOUNCE_CNT_W = cnt_width(DEBOUNCE_MS_DEF);
  localparam int unsigned HOLD_CNT_W     = cnt_width(LONG_MS_DEF);

endpackage

// File: rtl/key_debounce.sv
// One panel button: 2-FF synchronizer, optional inversion, debounce counter and
// rising-edge detector on the accepted level.
// Ports:
//   clk_1khz   - 1 kHz clock
//   switch_clr - asynchronous active-low reset
//   key_raw    - button pin (asynchronous)
//   level      - debounced (accepted) level, active-high
//   press      - one-cycle pulse on an accepted 0->1 transition
module key_debounce
  import setting_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter bit          INVERT      = 1'b0
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_MS);

  logic            sync1_q, sync2_q;
  logic            key_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            prev_q;

  // Synchronizer resets to the pin's idle value so reset never looks like a press.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign key_s = sync2_q ^ INVERT;

  // Count consecutive samples disagreeing with the accepted level; any agreeing
  // sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (key_s != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_MS - 1)) begin
        level_d = key_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/setting_input_ctrl.sv
// Time-setting input controller: conditions the three panel buttons, runs the
// button_1 auto-repeat and the IDLE/EDIT cursor FSM.
// Ports:
//   clk_1khz       - 1 kHz clock (1 cycle = 1 ms)
//   switch_clr     - asynchronous active-low reset
//   button_1       - increment button, active-high
//   button_2       - cursor-advance button, active-high
//   button_3_raw   - clear button, active-low at the pin
//   switch_setting - edit-mode enable level
//   flicker_mask   - one-hot cursor while editing, else 0 (bit i blanks digit i+1)
//   cursor         - selected digit
//   inc_pulse      - one-cycle increment for digit `cursor`
//   clr_pulse      - one-cycle clear for digit `cursor`
//   edit_active    - high while in EDIT
module setting_input_ctrl
  import setting_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int unsigned LONG_MS     = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS   = REPEAT_MS_DEF,
  parameter int unsigned N_DIGITS    = N_DIGITS_DEF
) (
  input  logic                clk_1khz,
  input  logic                switch_clr,
  input  logic                button_1,
  input  logic                button_2,
  input  logic                button_3_raw,
  input  logic                switch_setting,
  output logic [N_DIGITS-1:0] flicker_mask,
  output logic [2:0]          cursor,
  output logic                inc_pulse,
  output logic                clr_pulse,
  output logic                edit_active
);

  localparam int unsigned HoldW = cnt_width(LONG_MS);

  logic b1_level, b1_press;
  logic b2_level, b2_press;
  logic b3_level, b3_press;
  logic unused_levels;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .INVERT(1'b0)) u_key_1 (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .key_raw   (button_1),
    .level     (b1_level),
    .press     (b1_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .INVERT(1'b0)) u_key_2 (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .key_raw   (button_2),
    .level     (b2_level),
    .press     (b2_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .INVERT(1'b1)) u_key_3 (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .key_raw   (button_3_raw),
    .level     (b3_level),
    .press     (b3_press)
  );

  assign unused_levels = b2_level ^ b3_level;

  logic                set_s1_q, set_s2_q;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                rep_evt;
  state_e              state_q, state_d;
  logic [2:0]          cursor_q, cursor_d;
  logic                adv_q, adv_d;
  logic                inc_q, inc_d;
  logic                clr_q, clr_d;
  logic [N_DIGITS-1:0] flicker_q, flicker_d;

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      set_s1_q  <= 1'b0;
      set_s2_q  <= 1'b0;
      hold_q    <= '0;
      state_q   <= IDLE;
      cursor_q  <= '0;
      adv_q     <= 1'b0;
      inc_q     <= 1'b0;
      clr_q     <= 1'b0;
      flicker_q <= '0;
    end else begin
      set_s1_q  <= switch_setting;
      set_s2_q  <= set_s1_q;
      hold_q    <= hold_d;
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      adv_q     <= adv_d;
      inc_q     <= inc_d;
      clr_q     <= clr_d;
      flicker_q <= flicker_d;
    end
  end

  // Hold counter: 1 on the cycle after the press, repeat event when it reaches
  // LONG_MS, then reloaded so it hits LONG_MS again every REPEAT_MS cycles. It
  // never exceeds LONG_MS, so it cannot wrap however long the button is held.
  always_comb begin
    hold_d  = hold_q;
    rep_evt = 1'b0;
    if (!b1_level) begin
      hold_d = '0;
    end else if (b1_press) begin
      hold_d = HoldW'(1);
    end else if (hold_q == HoldW'(LONG_MS)) begin
      rep_evt = 1'b1;
      hold_d  = HoldW'(LONG_MS - REPEAT_MS + 1);
    end else if (hold_q != '0) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // A cursor advance is held back one cycle in adv_q so that a pulse issued in
  // the same slot is presented alongside the pre-advance cursor.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    adv_d    = 1'b0;
    inc_d    = 1'b0;
    clr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cursor_d = '0;
        if (set_s2_q) state_d = EDIT;
      end
      EDIT: begin
        if (!set_s2_q) begin
          // Leaving edit mode discards any event arriving in the same cycle.
          state_d  = IDLE;
          cursor_d = '0;
        end else begin
          if (adv_q) begin
            cursor_d = (cursor_q == 3'(N_DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;
          end
          adv_d = b2_press;
          clr_d = b3_press;
          inc_d = (b1_press | rep_evt) & ~b3_press;
        end
      end
      default: begin
        state_d  = IDLE;
        cursor_d = '0;
      end
    endcase
    flicker_d = (state_d == EDIT) ? (N_DIGITS'(1) << cursor_d) : '0;
  end

  assign flicker_mask = flicker_q;
  assign cursor       = cursor_q;
  assign inc_pulse    = inc_q;
  assign clr_pulse    = clr_q;
  assign edit_active  = (state_q == EDIT);

endmodule

// File: doc/setting_input_ctrl.md
# setting_input_ctrl

Input-side counterpart to the clock's display/beep path. It conditions the three panel buttons and drives the time-setting cursor. It produces the per-digit `flicker_mask` consumed by the 7-segment driver, plus one-cycle increment/clear commands for the timekeeping registers. It runs entirely in the `clk_1khz` domain, so 1 cycle = 1 ms.

## Interface
Parameters:
- `DEBOUNCE_MS`, 20: consecutive stable samples required to accept a new button level.
- `LONG_MS`, 1000: hold time on button_1 before auto-repeat starts.
- `REPEAT_MS`, 250: auto-repeat period while button_1 stays held.
- `N_DIGITS`, 6: number of editable display digits.

Ports:
- `clk_1khz` in 1: clock, 1 kHz.
- `switch_clr` in 1: reset; asynchronous, active-low.
- `button_1` in 1: Pulse, active-high; increments the selected digit.
- `button_2` in 1: QD, active-high; advances the cursor.
- `button_3_raw` in 1: CLR, active-low at the pin; inverted internally after synchronization.
- `switch_setting` in 1: edit-mode enable, level.
- `flicker_mask` out 6: one-hot of the cursor in EDIT, else 0. Bit i blanks digit i+1.
- `cursor` out 3: selected digit, 0..N_DIGITS-1.
- `inc_pulse` out 1: one-cycle increment command for digit `cursor`.
- `clr_pulse` out 1: one-cycle clear command for digit `cursor`.
- `edit_active` out 1: high while the FSM is in EDIT.

## Operation
- Every input, including `switch_setting`, passes through a 2-FF synchronizer. `button_3` is the inverted synchronized value.
- Debounce, per button:
  - A counter runs while the synchronized level differs from the accepted level, and clears when the levels match.
  - When the counter reaches DEBOUNCE_MS, the accepted level takes the synchronized value.
  - A press event is an accepted 0→1 transition, one cycle wide.
- Auto-repeat, button_1 only:
  - A hold counter starts at the press event.
  - At LONG_MS it generates a repeat event, then one more every REPEAT_MS while the accepted level stays 1.
  - An accepted release clears the hold counter.
  - The hold counter saturates and never wraps.
- FSM states:
  - IDLE: `cursor`=0, `flicker_mask`=0, no pulses, button events ignored. Moves to EDIT when the synchronized `switch_setting`=1.
  - EDIT:
    - A button_2 event advances `cursor` by 1, wrapping N_DIGITS-1 → 0.
    - A button_1 press or repeat event asserts `inc_pulse`.
    - A button_3 event asserts `clr_pulse`.
    - Moves to IDLE when `switch_setting`=0; `cursor` returns to 0 in the same transition.
- Simultaneous events in one cycle:
  - `clr_pulse` has priority over `inc_pulse`; the increment is dropped.
  - A cursor advance may coincide with either pulse. The pulse refers to the pre-advance `cursor`, which is the value shown on the same cycle.
- `switch_setting` falling in the same cycle as a button event: the event is discarded and no pulse is issued.
- All outputs are registered. `inc_pulse` and `clr_pulse` are never high for two consecutive cycles.

## Timing
- Reset (`switch_clr`=0), asynchronous:
  - All outputs go to 0, the FSM to IDLE, all counters to 0.
  - Accepted levels go to 0 (released), so a button held through reset yields a press event after release of reset plus debounce.
- Press-to-pulse latency: 2 (sync) + DEBOUNCE_MS + 1 (output register) = 23 cycles at defaults, measured from the first edge that samples the new level.
- Glitches shorter than DEBOUNCE_MS cycles produce no event.
- First repeat pulse: LONG_MS cycles after the initial `inc_pulse`. Later repeats every REPEAT_MS cycles.
- `flicker_mask` and `cursor` update on the cycle after the button_2 event.
- Setting mode: `edit_active` asserts 3 cycles after `switch_setting` rises (2 sync + 1 register).
- Reset mid-debounce or mid-hold abandons the operation; no pulse is emitted afterwards.

## Structure
- Package `setting_pkg` holds:
  - the FSM state enum {IDLE, EDIT};
  - N_DIGITS and the default ms constants;
  - a `clog2`-based width constant for the debounce and hold counters.
- Sub-module `key_debounce`: synchronizer, optional inversion, debounce counter, edge detector. It is instantiated three times and outputs the accepted level and the press event.
- The top holds the auto-repeat counter, the FSM and the output registers.

## Test plan
- Reset then EDIT: release `switch_clr`, raise `switch_setting` → `edit_active`=1 after 3 cycles, `cursor`=0, `flicker_mask`=6'b000001.
- Debounce: button_1 10-cycle glitch → no `inc_pulse`. 30-cycle press → exactly one `inc_pulse`, 23 cycles after the press.
- Cursor wrap: six button_2 presses → `cursor` goes 1,2,3,4,5,0 and `flicker_mask` tracks one-hot. In IDLE, button_2 leaves `cursor`=0.
- Auto-repeat: hold button_1 for 2000 cycles → pulses at t0, t0+1000, t0+1250, t0+1500, t0+1750. Release → no further pulses.
- Priority: button_1 and button_3_raw asserted on the same cycle for 30 cycles → a single `clr_pulse` and no `inc_pulse`.
- Reset mid-operation: assert `switch_clr` at 15 cycles into a button_1 press → outputs 0 immediately. After release with the button still held, one `inc_pulse` arrives 23 cycles later.
